// File: rtl/pfu_pkg.sv
// rtl/pfu_pkg.sv - shared widths, constants and buffer entry type for the prefetch unit
`ifndef PFU_DEFINES_SVH
`define PFU_DEFINES_SVH
`define INST_WIDTH 32
`define PC_WIDHT 32
`define ZERO_INST 32'h0000_0000
`define ZERO_PC 32'h0000_0000
`define PC_INC 4
`endif

package pfu_pkg;

  localparam int INST_W = `INST_WIDTH;
  localparam int PC_W   = `PC_WIDHT;

  // One buffered fetch: the instruction word and the address it came from.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Redirect targets are forced onto a word boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    logic [PC_W-1:0] r;
    r      = pc;
    r[1:0] = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/pfu_fifo.sv
// rtl/pfu_fifo.sv - synchronous FIFO with clear and occupancy count for fetched instructions
module pfu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop, full;

  // Next state: clear wins over everything, pointers wrap naturally (power-of-two depth).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    full     = (count_q == CNT_W'(DEPTH));
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && (!full || do_pop);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage and pointers; storage is zeroed so the head reads as zero out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/pfu.sv
// rtl/pfu.sv - instruction prefetch unit: credit-limited fetch, in-order response capture, flush handling
module pfu
  import pfu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              pfu2imem_req_o,
  output logic [PC_W-1:0]   pfu2imem_addr_o,
  input  logic              imem2pfu_gnt_i,
  input  logic              imem2pfu_rvalid_i,
  input  logic [INST_W-1:0] imem2pfu_rdata_i,
  input  logic              ctrl2pfu_flush_i,
  input  logic [PC_W-1:0]   ctrl2pfu_branch_pc_i,
  input  logic              ctrl2pfu_stall_i,
  output logic              pfu2dpu_valid_o,
  output logic [INST_W-1:0] pfu2dpu_inst_o,
  output logic [PC_W-1:0]   pfu2dpu_pc_o,
  input  logic              dpu2pfu_ready_i
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W  = CNT_W + 1;
  // Discards can pile up across back-to-back redirects, so give them headroom.
  localparam int DROP_W = CNT_W + 4;

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]   resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  fifo_count;
  logic [SUM_W-1:0]  credit_used;
  logic              fifo_empty, fifo_push, fifo_pop;
  logic              grant, keep_rsp;
  fetch_entry_t      push_entry, head_entry;

  // Request credit and per-cycle transfer decisions; a flush suppresses all of them.
  always_comb begin
    credit_used    = SUM_W'(fifo_count) + SUM_W'(outstanding_q);
    pfu2imem_req_o = !rst_i && !ctrl2pfu_stall_i && !ctrl2pfu_flush_i &&
                     (credit_used < SUM_W'(FIFO_DEPTH));
    grant          = pfu2imem_req_o && imem2pfu_gnt_i;
    keep_rsp       = imem2pfu_rvalid_i && !ctrl2pfu_flush_i && (drop_cnt_q == '0);
    fifo_push      = keep_rsp;
    fifo_pop       = !fifo_empty && dpu2pfu_ready_i && !ctrl2pfu_flush_i;
    push_entry     = '{inst: imem2pfu_rdata_i, pc: resp_pc_q};
  end

  // Address and bookkeeping updates; on redirect every live in-flight response becomes a discard.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (ctrl2pfu_flush_i) begin
      fetch_pc_d    = align_pc(ctrl2pfu_branch_pc_i);
      resp_pc_d     = align_pc(ctrl2pfu_branch_pc_i);
      drop_cnt_d    = drop_cnt_q + DROP_W'(outstanding_q) - DROP_W'(imem2pfu_rvalid_i);
      outstanding_d = '0;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + PC_W'(`PC_INC);
      end
      if (imem2pfu_rvalid_i && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - DROP_W'(1);
      end
      if (keep_rsp) begin
        resp_pc_d = resp_pc_q + PC_W'(`PC_INC);
      end
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(keep_rsp);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  pfu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (ctrl2pfu_flush_i),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pfu2imem_addr_o = fetch_pc_q;
  assign pfu2dpu_valid_o = !fifo_empty;
  assign pfu2dpu_inst_o  = head_entry.inst;
  assign pfu2dpu_pc_o    = head_entry.pc;

  // A response when nothing is owed means the memory side broke the handshake.
  assert property (@(posedge clk_i) disable iff (rst_i)
    imem2pfu_rvalid_i |-> ((outstanding_q != '0) || (drop_cnt_q != '0)));

endmodule
